icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller. Serves fetch lookups combinationally on a hit (zero-cycle latency). On a miss it issues a single-word read to the memory controller, fills the line, and serves the fetch in the cycle after the fill.

---
 rtl/icache.sv | 124 ++++++++++++
 tb/tb_icache.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped, one-word-per-line instruction cache. Hits are
//            served combinationally; misses issue a single-word memory read.
// Revision : 1.0
// ============================================================================
module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_req,
    input  logic [31:0] pc_in,
    output logic        cache_rdy,
    output logic [31:0] inst_out,
    output logic        icache2mem_req,
    output logic [31:0] icache2mem_addr,
    input  logic        mem2icache_rdy,
    input  logic [31:0] mem2icache_data
);

    localparam int c_LINES = 1 << INDEX_WIDTH;
    localparam int c_TAG_W = 30 - INDEX_WIDTH;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_LINES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag  [c_LINES];
    logic [31:0]        r_data [c_LINES];
    logic [29:0]        r_miss_wa;

    logic [INDEX_WIDTH-1:0] w_index;
    logic [c_TAG_W-1:0]     w_tag;
    logic [INDEX_WIDTH-1:0] w_miss_index;
    logic [c_TAG_W-1:0]     w_miss_tag;
    logic                   w_hit;
    logic                   w_miss_start;
    logic                   w_fill;
    logic                   w_unused_pc_bits;

    assign w_index          = pc_in[INDEX_WIDTH+1:2];
    assign w_tag            = pc_in[31:INDEX_WIDTH+2];
    assign w_miss_index     = r_miss_wa[INDEX_WIDTH-1:0];
    assign w_miss_tag       = r_miss_wa[29:INDEX_WIDTH];
    assign w_hit            = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_unused_pc_bits = &{1'b0, pc_in[1:0]};

    // Every state update is gated by rdy_in so the cache freezes with the
    // memory controller.
    assign w_miss_start = rdy_in && (r_state == c_IDLE) && fetch_req && !w_hit;
    assign w_fill       = rdy_in && (r_state == c_WAIT) && mem2icache_rdy;

    // State register
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= c_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; pc_in/fetch_req are ignored while waiting on memory.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (fetch_req && !w_hit) begin
                    w_state_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (mem2icache_rdy) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cache_rdy      = 1'b0;
        icache2mem_req = 1'b0;
        case (r_state)
            c_IDLE:  cache_rdy      = rdy_in && fetch_req && w_hit;
            c_WAIT:  icache2mem_req = 1'b1;
            default: cache_rdy      = 1'b0;
        endcase
    end

    assign inst_out        = r_data[w_index];
    assign icache2mem_addr = {r_miss_wa, 2'b00};

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_miss_wa <= '0;
        end else if (w_miss_start) begin
            r_miss_wa <= pc_in[31:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_miss_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_miss_index]  <= w_miss_tag;
            r_data[w_miss_index] <= mem2icache_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Brief    : Self-checking bench for icache against a line-map reference model.
// Revision : 1.0
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        fetch_req;
    logic [31:0] pc_in;
    logic        cache_rdy;
    logic [31:0] inst_out;
    logic        icache2mem_req;
    logic [31:0] icache2mem_addr;
    logic        mem2icache_rdy;
    logic [31:0] mem2icache_data;

    int checks = 0;
    int errors = 0;

    // Reference model: which word address each line holds, and the pending miss.
    bit          m_valid [64];
    logic [29:0] m_line  [64];
    bit          m_pending;
    logic [29:0] m_miss;

    icache #(.INDEX_WIDTH(6)) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .fetch_req       (fetch_req),
        .pc_in           (pc_in),
        .cache_rdy       (cache_rdy),
        .inst_out        (inst_out),
        .icache2mem_req  (icache2mem_req),
        .icache2mem_addr (icache2mem_addr),
        .mem2icache_rdy  (mem2icache_rdy),
        .mem2icache_data (mem2icache_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (wa == 30'd0) return 32'h0000_0093;
        return ({2'b00, wa} * 32'h9E37_79B1) + 32'h0000_0007;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_miss    = '0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
        end
    endtask

    // One clock cycle: drive at negedge, check just before posedge, then advance the model.
    task automatic step(input bit rst, input bit rdy, input bit freq,
                        input logic [31:0] pc, input bit mrdy);
        int idx;
        bit hit;
        bit exp_rdy;
        rst_in          = rst;
        rdy_in          = rdy;
        fetch_req       = freq;
        pc_in           = pc;
        mem2icache_rdy  = mrdy;
        mem2icache_data = mrdy ? mem_word(m_miss) : $urandom();
        #4;
        idx     = int'((pc >> 2) % 32'd64);
        hit     = m_valid[idx] && (m_line[idx] == pc[31:2]);
        exp_rdy = !m_pending && rdy && freq && hit;
        check("cache_rdy", 32'(cache_rdy), 32'(exp_rdy));
        check("mem_req", 32'(icache2mem_req), 32'(m_pending));
        check("mem_addr", icache2mem_addr, {m_miss, 2'b00});
        if (exp_rdy) check("inst_out", inst_out, mem_word(pc[31:2]));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            if (m_pending) begin
                if (mrdy) begin
                    m_valid[int'(m_miss % 30'd64)] = 1'b1;
                    m_line[int'(m_miss % 30'd64)]  = m_miss;
                    m_pending = 1'b0;
                end
            end else if (freq && !hit) begin
                m_pending = 1'b1;
                m_miss    = pc[31:2];
            end
        end
        @(negedge clk);
    endtask

    // Miss on pc, memory answers lat cycles after the miss cycle.
    task automatic fill(input logic [31:0] pc, input int lat);
        step(0, 1, 1, pc, 0);
        for (int k = 1; k < lat; k++) step(0, 1, 1, pc, 0);
        step(0, 1, 1, pc, 1);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; fetch_req = 1'b0; pc_in = '0;
        mem2icache_rdy = 1'b0; mem2icache_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state, idle without request on an uncached address
        step(0, 1, 0, 32'h0000_0000, 0);
        step(0, 1, 0, 32'h0000_0444, 0);

        // Cold miss with a three-cycle memory response, then hit
        fill(32'h0000_0000, 3);
        step(0, 1, 1, 32'h0000_0000, 0);
        check("cold_inst", inst_out, 32'h0000_0093);

        // Streaming hits
        fill(32'h0000_0004, 1);
        fill(32'h0000_0008, 2);
        step(0, 1, 1, 32'h0000_0000, 0);
        step(0, 1, 1, 32'h0000_0004, 0);
        step(0, 1, 1, 32'h0000_0008, 0);

        // Conflict eviction on index 4
        fill(32'h0000_0010, 1);
        step(0, 1, 1, 32'h0000_0010, 0);
        fill(32'h0000_0110, 2);
        step(0, 1, 1, 32'h0000_0110, 0);
        fill(32'h0000_0010, 1);
        step(0, 1, 1, 32'h0000_0010, 0);

        // Redirect during WAIT
        step(0, 1, 1, 32'h0000_0020, 0);
        step(0, 1, 1, 32'h0000_0080, 0);
        step(0, 1, 0, 32'h0000_0080, 1);
        step(0, 1, 1, 32'h0000_0080, 0);
        step(0, 1, 1, 32'h0000_0044, 0);
        step(0, 1, 1, 32'h0000_0044, 1);
        step(0, 1, 1, 32'h0000_0020, 0);
        step(0, 1, 1, 32'h0000_0080, 0);

        // Freeze during WAIT ignores the pulse, then completes
        step(0, 1, 1, 32'h0000_0030, 0);
        step(0, 0, 1, 32'h0000_0030, 1);
        step(0, 0, 1, 32'h0000_0000, 1);
        step(0, 1, 1, 32'h0000_0030, 0);
        step(0, 1, 1, 32'h0000_0030, 1);
        step(0, 1, 1, 32'h0000_0030, 0);
        step(0, 0, 1, 32'h0000_0030, 0);

        // Pulse in IDLE is ignored
        step(0, 1, 0, 32'h0000_0050, 1);

        // Reset during WAIT drops the request and clears the cache
        step(0, 1, 1, 32'h0000_0040, 0);
        step(1, 1, 1, 32'h0000_0040, 0);
        step(0, 1, 0, 32'h0000_0000, 0);
        step(0, 1, 1, 32'h0000_0000, 0);
        step(0, 1, 1, 32'h0000_0000, 1);
        step(0, 1, 1, 32'h0000_0000, 0);

        // Randomized traffic over a small aliasing address set
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] pc;
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) != 0), pc, ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
